// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes and datapath widths
package alu_pkg;
  localparam int ALU_W = 32;
  localparam int REQ_ID_W = 1;
  typedef enum logic [2:0] {
    OP_NOOP0 = 3'b000,
    OP_NOOP1 = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHR   = 3'b101,
    OP_ADDI  = 3'b110,
    OP_SUBI  = 3'b111
  } alu_op_e;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; immediate forms take their immediate on b, shift amount is b[4:0]
module alu
  import alu_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] y
);
  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      OP_ADD, OP_ADDI: y = a + b;
      OP_SUB, OP_SUBI: y = a - b;
      OP_SHL:          y = a << b[4:0];
      OP_SHR:          y = a >> b[4:0];
      default:         y = '0;
    endcase
  end
endmodule

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: two-way round-robin picker; on contention the requester that did not win last time wins
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one ALU between two requesters; ALU_SHARE_ARB_CNT_EN adds op/stall counters
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int NREQ  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][2:0]       req_op,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic [REQ_ID_W-1:0]        rsp_id
`ifdef ALU_SHARE_ARB_CNT_EN
  ,
  output logic [31:0]                op_count,
  output logic [31:0]                stall_count
`endif
);
  logic [NREQ-1:0] grant;
  logic last_grant, can_accept, acc, win;
  logic [WIDTH-1:0] alu_y;
  alu_rr_pick u_pick (.valid(req_valid), .last(last_grant), .grant(grant));
  // no handshake completes while reset is held
  always_comb begin
    can_accept = (~rsp_valid | rsp_ready) & ~rst;
    req_ready = grant & {NREQ{can_accept}};
    acc = |req_ready;
    win = grant[1];
  end
  alu u_alu (.op(req_op[win]), .a(req_a[win]), .b(req_b[win]), .y(alu_y));
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_id <= '0;
      last_grant <= 1'b1;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_result <= alu_y;
      rsp_id <= win;
      last_grant <= win;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`ifdef ALU_SHARE_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
      stall_count <= '0;
    end else begin
      op_count <= op_count + 32'(acc);
      stall_count <= stall_count + 32'(rsp_valid & ~rsp_ready);
    end
  end
`endif
endmodule
